// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and the operation units it drives.
// State encodings stay as plain localparams so older units can use them too.
package alu_pkg;

    // Default widths and unit count for a standard four-unit ALU.
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_OP_W    = 2;
    localparam int DEF_N_OPS   = 4;
    localparam int DEF_TIMEOUT = 15;

    // Sequencer state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    // Opcode assignment.
    // The unit attached to enable bit k must implement opcode k.
    localparam int OP_COMPLEMENTO = 0;
    localparam int OP_SUMA        = 1;
    localparam int OP_RESTA       = 2;
    localparam int OP_AND         = 3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for a done line coming back from an operation unit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops.
    // The first flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/alu_secuenciador.sv
// ALU sequencer: starts one operation unit per request and waits for its done.
// It then captures the unit's result, waits for the unit to drop done, and pulses
// its own done. Every wait on a unit is bounded, so a dead unit cannot hang the ALU.
module alu_secuenciador
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_OPS   = DEF_N_OPS,
    parameter int OP_W    = DEF_OP_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OP_W-1:0]         opcode,
    input  logic [2*DATA_W-1:0]     data_in,
    output logic [2*DATA_W-1:0]     op_data,
    output logic [N_OPS-1:0]        op_enable,
    input  logic [N_OPS-1:0]        op_done,
    input  logic [N_OPS*DATA_W-1:0] op_result,
    output logic [DATA_W-1:0]       result,
    output logic                    done,
    output logic                    busy,
    output logic                    error
);

    // The counter is sized for the timeout, not for the opcode width.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [OP_W-1:0]       r_sel;
    logic [2*DATA_W-1:0]   r_op_data;
    logic [N_OPS-1:0]      r_op_enable;
    logic [DATA_W-1:0]     r_result;
    logic                  r_done;
    logic                  r_error;

    logic [N_OPS-1:0]      w_ds_vec;
    logic                  w_ds;
    logic [DATA_W-1:0]     w_sel_result;
    logic [N_OPS-1:0]      w_start_onehot;
    logic                  w_op_valid;
    logic                  w_cnt_last;
    logic [1:0]            w_next_state;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_capture;
    logic                  w_wait_to;
    logic                  w_rel_ok;
    logic                  w_rel_to;

    // Each unit's done line is asynchronous to us, so every bit gets its own synchronizer.
    genvar g;
    generate
        for (g = 0; g < N_OPS; g++) begin : g_sync
            sync_2ff u_sync (
                .clk (clk),
                .rst (rst),
                .d   (op_done[g]),
                .q   (w_ds_vec[g])
            );
        end
    endgenerate

    // Decode the incoming opcode to a one-hot enable.
    // An opcode with no matching unit decodes to all zeros, which marks it invalid.
    always_comb begin
        w_start_onehot = '0;
        for (int k = 0; k < N_OPS; k++) begin
            if (opcode == OP_W'(k)) begin
                w_start_onehot[k] = 1'b1;
            end
        end
    end

    assign w_op_valid = |w_start_onehot;

    // Follow only the selected unit.
    // Done lines and results from the other units are ignored.
    always_comb begin
        w_ds         = 1'b0;
        w_sel_result = '0;
        for (int k = 0; k < N_OPS; k++) begin
            if (r_sel == OP_W'(k)) begin
                w_ds         = w_ds_vec[k];
                w_sel_result = op_result[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Next-state logic and one-cycle event strobes for the register blocks below.
    // A done line that is already high on entry to WAIT counts as completion.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_capture    = 1'b0;
        w_wait_to    = 1'b0;
        w_rel_ok     = 1'b0;
        w_rel_to     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_op_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_ds) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RELEASE;
                end else if (w_cnt_last) begin
                    w_wait_to    = 1'b1;
                    w_next_state = ST_FINISH;
                end
            end
            ST_RELEASE: begin
                if (!w_ds) begin
                    w_rel_ok     = 1'b1;
                    w_next_state = ST_FINISH;
                end else if (w_cnt_last) begin
                    w_rel_to     = 1'b1;
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register and timeout counter.
    // The counter restarts on every state change and stays at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || (r_state == ST_IDLE) || (r_state == ST_FINISH)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Unit enable.
    // It is set only when a request is accepted and cleared on completion or timeout.
    // The async reset drops it immediately, even in the middle of an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_enable <= '0;
        end else if (w_accept) begin
            r_op_enable <= w_start_onehot;
        end else if (w_capture || w_wait_to || (r_state != ST_WAIT)) begin
            r_op_enable <= '0;
        end
    end

    // Latch the opcode and operands when a request is accepted.
    // They then hold steady on the shared operand bus for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_op_data <= '0;
        end else if (w_accept) begin
            r_sel     <= opcode;
            r_op_data <= data_in;
        end
    end

    // Capture the selected unit's result once its done is seen.
    // A timeout leaves the previous result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_capture) begin
            r_result <= w_sel_result;
        end
    end

    // Completion pulse and sticky error flag.
    // The error flag clears only when a good request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= w_reject || w_wait_to || w_rel_ok || w_rel_to;
            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_reject || w_wait_to || w_rel_to) begin
                r_error <= 1'b1;
            end
        end
    end

    // done is raised on the edge that enters FINISH.
    // busy therefore covers only WAIT and RELEASE, so it is already low during the done cycle.
    assign busy      = (r_state == ST_WAIT) || (r_state == ST_RELEASE);
    assign done      = r_done;
    assign error     = r_error;
    assign result    = r_result;
    assign op_data   = r_op_data;
    assign op_enable = r_op_enable;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Testbench for alu_secuenciador.
// The stimulus process queues the expected result, error and done cycle for each request,
// and a monitor process compares them whenever done appears.
module tb_alu_secuenciador;
   import alu_pkg::*;

   localparam int DATA_W  = 4;
   localparam int N_OPS   = 4;
   localparam int OP_W    = 3;
   localparam int TIMEOUT = 15;

   typedef struct {
      logic [3:0] res;
      logic       err;
      int         cyc;
      string      name;
   } exp_t;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic [OP_W-1:0]         opcode = '0;
   logic [2*DATA_W-1:0]     dataIn = '0;
   logic [2*DATA_W-1:0]     opData;
   logic [N_OPS-1:0]        opEnable;
   logic [N_OPS-1:0]        opDone;
   logic [N_OPS*DATA_W-1:0] opResult;
   logic [DATA_W-1:0]       result;
   logic                    done;
   logic                    busy;
   logic                    error;

   int         cyc = 0;
   int         nCompared = 0;
   int         nMismatched = 0;
   int         unitMode = 0;
   logic [3:0] holdDone = '0;
   logic [3:0] uA;
   logic [3:0] uB;
   exp_t       sb[$];

   alu_secuenciador #(
      .DATA_W (DATA_W),
      .N_OPS  (N_OPS),
      .OP_W   (OP_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clock),
      .rst      (reset),
      .start    (start),
      .opcode   (opcode),
      .data_in  (dataIn),
      .op_data  (opData),
      .op_enable(opEnable),
      .op_done  (opDone),
      .op_result(opResult),
      .result   (result),
      .done     (done),
      .busy     (busy),
      .error    (error)
   );

   // 10 ns clock, plus a cycle counter used to timestamp the done pulses.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Unit responder models.
   // Mode 0: done follows enable with no delay.
   // Mode 1: done never rises.
   // Mode 2: done rises with enable and then stays high.
   always @(posedge clock) holdDone <= (unitMode == 2) ? (holdDone | opEnable) : 4'b0000;

   always_comb begin
      case (unitMode)
         1:       opDone = 4'b0000;
         2:       opDone = opEnable | holdDone;
         default: opDone = opEnable;
      endcase
   end

   // Unit datapaths computed from the shared operand bus, one slice per opcode.
   always_comb begin
      uA = opData[7:4];
      uB = opData[3:0];
      opResult[OP_COMPLEMENTO*4 +: 4] = ~uA;
      opResult[OP_SUMA*4 +: 4]        = uA + uB;
      opResult[OP_RESTA*4 +: 4]       = uA - uB;
      opResult[OP_AND*4 +: 4]         = uA & uB;
   end

   task automatic checkOutput(input string nm, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", nm, actual, expected);
      end
   endtask

   // Monitor: each done pulse pops one expectation and checks it.
   always @(negedge clock) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, int'(result), int'(e.res));
            checkOutput({e.name, "_error"}, int'(error), int'(e.err));
            checkOutput({e.name, "_done_cycle"}, cyc, e.cyc);
            checkOutput({e.name, "_busy_at_done"}, int'(busy), 0);
            checkOutput({e.name, "_enable_at_done"}, int'(opEnable), 0);
         end
      end
   end

   // Issue one request, queue its expected outcome, then scramble the inputs.
   // The sequencer must keep the latched copy, so the scrambled inputs have no effect.
   task automatic applyStimulus(input int op, input logic [7:0] din, input logic [3:0] expRes,
                                input logic expErr, input int lat, input string nm);
      @(negedge clock);
      start  = 1'b1;
      opcode = OP_W'(op);
      dataIn = din;
      sb.push_back('{res: expRes, err: expErr, cyc: cyc + 1 + lat, name: nm});
      @(negedge clock);
      start  = 1'b0;
      opcode = OP_W'(op) ^ 3'b001;
      dataIn = ~din;
   endtask

   // Wait, with a bound, until the monitor has consumed every queued expectation.
   task automatic waitDrain(input int bound, input string nm);
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         #1;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s_timeout: got %0d pending, expected 0", nm, sb.size());
         sb.delete();
      end
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state.
      #3;
      checkOutput("rst_enable", int'(opEnable), 0);
      checkOutput("rst_opdata", int'(opData), 0);
      checkOutput("rst_result", int'(result), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_error", int'(error), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // T1: complement unit. ~A of 8'hA5 is 4'h5, done 6 clocks after the start edge.
      applyStimulus(OP_COMPLEMENTO, 8'hA5, 4'h5, 1'b0, 6, "t1");
      checkOutput("t1_enable", int'(opEnable), 1);
      checkOutput("t1_busy", int'(busy), 1);
      @(negedge clock);
      checkOutput("t1_opdata", int'(opData), 'hA5);
      waitDrain(40, "t1");

      // Other units: 3+7=A, 5-2=3, C&6=4.
      applyStimulus(OP_SUMA, 8'h37, 4'hA, 1'b0, 6, "add");
      checkOutput("add_enable", int'(opEnable), 2);
      waitDrain(40, "add");
      applyStimulus(OP_RESTA, 8'h52, 4'h3, 1'b0, 6, "sub");
      checkOutput("sub_enable", int'(opEnable), 4);
      waitDrain(40, "sub");
      applyStimulus(OP_AND, 8'hC6, 4'h4, 1'b0, 6, "and");
      checkOutput("and_enable", int'(opEnable), 8);
      waitDrain(40, "and");

      // T2: unit never answers. WAIT aborts after 15 clocks and the result stays 4.
      unitMode = 1;
      applyStimulus(OP_SUMA, 8'h11, 4'h4, 1'b1, 15, "t2");
      checkOutput("t2_enable", int'(opEnable), 2);
      waitDrain(40, "t2");
      unitMode = 0;
      repeat (4) @(negedge clock);

      // T3: done stuck high. Result 9-4=5 is captured, then RELEASE times out at +18.
      unitMode = 2;
      applyStimulus(OP_RESTA, 8'h94, 4'h5, 1'b0 | 1'b1, 18, "t3");
      waitDrain(40, "t3");
      unitMode = 0;
      repeat (4) @(negedge clock);

      // T4: a second start during WAIT is ignored. The new request clears error; F&3=3.
      applyStimulus(OP_AND, 8'hF3, 4'h3, 1'b0, 6, "t4");
      checkOutput("t4_error_cleared", int'(error), 0);
      checkOutput("t4_enable", int'(opEnable), 8);
      start  = 1'b1;
      opcode = 3'd0;
      dataIn = 8'h00;
      @(negedge clock);
      start = 1'b0;
      checkOutput("t4_enable_held", int'(opEnable), 8);
      checkOutput("t4_opdata_held", int'(opData), 'hF3);
      waitDrain(40, "t4");
      applyStimulus(OP_COMPLEMENTO, 8'h3C, 4'hC, 1'b0, 6, "t4_next");
      waitDrain(40, "t4_next");

      // T5: opcode 4 has no unit. Expect error plus done on the sampling edge, and no enable.
      applyStimulus(4, 8'hFF, 4'hC, 1'b1, 0, "t5");
      checkOutput("t5_enable", int'(opEnable), 0);
      checkOutput("t5_busy", int'(busy), 0);
      @(negedge clock);
      checkOutput("t5_error_held", int'(error), 1);
      checkOutput("t5_done_pulse_end", int'(done), 0);
      waitDrain(10, "t5");

      // T6: async reset in the middle of WAIT clears the outputs without a clock edge.
      applyStimulus(OP_SUMA, 8'h25, 4'h7, 1'b0, 6, "t6");
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      checkOutput("t6_enable", int'(opEnable), 0);
      checkOutput("t6_busy", int'(busy), 0);
      checkOutput("t6_done", int'(done), 0);
      checkOutput("t6_error", int'(error), 0);
      checkOutput("t6_result", int'(result), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      applyStimulus(OP_COMPLEMENTO, 8'hA5, 4'h5, 1'b0, 6, "t6_after");
      checkOutput("t6_after_enable", int'(opEnable), 1);
      waitDrain(40, "t6_after");

      repeat (3) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
